// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through its four input vectors, waits a settle time on each,
// samples Y and compares the captured truth table against EXPECTED.
//
// state    | meaning
// S_IDLE   | waiting for start, A/B parked at 0
// S_SETTLE | driving vector idx, counting down the settle time
// S_SAMPLE | vector still held, Y captured at the closing edge
// S_DONE   | one-cycle completion pulse, pass valid
module gate_truth_checker #(
    parameter logic [3:0] EXPECTED = 4'b1001,
    parameter int         SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic [3:0] fail_mask
);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("gate_truth_checker: SETTLE must be in 1..255");
    end

    localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [3:0] result_nxt, fail_nxt;
    logic       pass_nxt;
    logic       a_nxt, b_nxt, busy_nxt, done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 2'd0;
            cnt       <= 8'd0;
            result    <= 4'b0000;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            result    <= result_nxt;
            fail_mask <= fail_nxt;
            pass      <= pass_nxt;
            a_out     <= a_nxt;
            b_out     <= b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        result_nxt = result;
        fail_nxt   = fail_mask;
        pass_nxt   = pass;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_SETTLE;
                    idx_nxt    = 2'd0;
                    cnt_nxt    = RELOAD;
                    result_nxt = 4'b0000;
                    fail_nxt   = 4'b0000;
                    pass_nxt   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = S_SAMPLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            S_SAMPLE: begin
                // !== flags X/Z on Y in simulation; synthesises as a plain compare
                result_nxt[idx] = y_in;
                fail_nxt[idx]   = (y_in !== EXPECTED[idx]);
                if (idx == 2'd3) begin
                    state_nxt = S_DONE;
                    pass_nxt  = (fail_nxt == 4'b0000);
                end else begin
                    state_nxt = S_SETTLE;
                    idx_nxt   = idx + 2'd1;
                    cnt_nxt   = RELOAD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so nothing combinational reaches a pin
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        if (state_nxt == S_SETTLE || state_nxt == S_SAMPLE) begin
            a_nxt = idx_nxt[1];
            b_nxt = idx_nxt[0];
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: gate models on y_in, expected run results
// queued at start and compared when done pulses.
module tb_gate_truth_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst, start0, start1;
    int         mode0;
    logic       y0, a0, b0, busy0, done0, pass0;
    logic [3:0] res0, fm0;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [3:0] res1, fm1;

    // mode0: 0 XNOR, 1 XOR, 2 stuck-at-0, 3 undriven
    assign y0 = (mode0 == 0) ? ~(a0 ^ b0) :
                (mode0 == 1) ?  (a0 ^ b0) :
                (mode0 == 2) ? 1'b0 : 1'bz;
    assign y1 = a1 & b1;

    gate_truth_checker u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .y_in(y0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
        .result(res0), .fail_mask(fm0)
    );

    gate_truth_checker #(.EXPECTED(4'b1000), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .result(res1), .fail_mask(fm1)
    );

    int         sel = 0;
    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [3:0] o_res, o_fm;
    assign o_a    = sel ? a1 : a0;
    assign o_b    = sel ? b1 : b0;
    assign o_busy = sel ? busy1 : busy0;
    assign o_done = sel ? done1 : done0;
    assign o_pass = sel ? pass1 : pass0;
    assign o_res  = sel ? res1 : res0;
    assign o_fm   = sel ? fm1 : fm0;

    typedef struct {
        logic [3:0] r;
        logic [3:0] f;
        logic       p;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 0) start0 = v;
        else        start1 = v;
    endtask

    // Start a run on DUT s; poke re-asserts start in that relative cycle of the run.
    task automatic run(input int s, input logic [3:0] er, input logic [3:0] ef, input logic ep,
                       input int lat, input int settle, input int poke);
        exp_t e;
        int   st, rel, dc;
        bit   seen;
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        st = cyc;
        e  = '{r: er, f: ef, p: ep, lat: lat};
        sb.push_back(e);
        seen = 0;
        dc   = 0;
        for (int k = 0; k < lat + 20 && !seen; k++) begin
            @(negedge clk);
            rel = cyc - st;
            set_start(s, (rel == poke) ? 1'b1 : 1'b0);
            if (o_done) begin
                seen = 1;
                dc   = rel;
                check("done_ab", 16'({o_a, o_b}), 16'd0);
                check("done_busy", 16'(o_busy), 16'd1);
            end else if (rel < lat) begin
                check("run_busy", 16'(o_busy), 16'd1);
                check("vector_hold", 16'({o_a, o_b}), 16'((rel - 1) / (settle + 1)));
            end
        end
        set_start(s, 1'b0);
        e = sb.pop_front();
        check("done_seen", 16'(seen), 16'd1);
        check("latency", 16'(dc), 16'(e.lat));
        check("result", 16'(o_res), 16'(e.r));
        check("fail_mask", 16'(o_fm), 16'(e.f));
        @(negedge clk);
        check("done_single", 16'(o_done), 16'd0);
        check("idle_busy", 16'(o_busy), 16'd0);
        check("pass", 16'(o_pass), 16'(e.p));
        check("result_hold", 16'(o_res), 16'(e.r));
    endtask

    logic [3:0] z_res, z_fm;
    int st, d;
    bit seen;

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0;
        repeat (3) @(negedge clk);
        check("rst_dut0", {3'd0, a0, b0, busy0, done0, pass0, res0, fm0}, 16'd0);
        check("rst_dut1", {3'd0, a1, b1, busy1, done1, pass1, res1, fm1}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        mode0 = 0;
        run(0, 4'b1001, 4'b0000, 1'b1, 13, 2, -1);

        mode0 = 1;
        run(0, 4'b0110, 4'b1111, 1'b0, 13, 2, -1);

        mode0 = 2;
        run(0, 4'b0000, 4'b1001, 1'b0, 13, 2, -1);

        // Undriven Y: expected capture follows whatever this simulator resolves Z to
        mode0 = 3;
        #1;
        z_res = {4{y0}};
        z_fm  = (y0 === 1'b0) ? 4'b1001 : (y0 === 1'b1) ? 4'b0110 : 4'b1111;
        run(0, z_res, z_fm, 1'b0, 13, 2, -1);

        mode0 = 0;
        run(0, 4'b1001, 4'b0000, 1'b1, 13, 2, 4);
        repeat (5) begin
            @(negedge clk);
            check("no_extra_done", 16'(done0), 16'd0);
        end

        // start held high: back-to-back runs with one idle cycle
        sel = 0;
        @(negedge clk);
        start0 = 1'b1;
        st = cyc;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        d = cyc;
        check("held_done1", 16'(seen), 16'd1);
        check("held_lat1", 16'(d - st), 16'd13);
        @(negedge clk);
        check("held_idle_gap", 16'(busy0), 16'd0);
        @(negedge clk);
        check("held_restart", 16'(busy0), 16'd1);
        start0 = 1'b0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        check("held_done2", 16'(seen), 16'd1);
        check("held_lat2", 16'(cyc - d), 16'd14);
        @(negedge clk);
        check("held_pass", 16'(pass0), 16'd1);

        // reset during SAMPLE of vector 2
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        st = cyc;
        @(negedge clk);
        start0 = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_rst_vec", 16'({a0, b0}), 16'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst", {3'd0, a0, b0, busy0, done0, pass0, res0, fm0}, 16'd0);
        repeat (15) begin
            @(negedge clk);
            check("no_done_after_rst", 16'({done0, busy0}), 16'd0);
        end
        run(0, 4'b1001, 4'b0000, 1'b1, 13, 2, -1);

        run(1, 4'b1000, 4'b0000, 1'b1, 9, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
